// File: rtl/spi_flash_ctrl.sv
// Read sequencer for SPI NOR flash sitting in front of spi_master: one request -> READ header + byte stream.
// Define SPI_FLASH_WAKE_EN to issue a release-from-power-down command after reset.
module spi_flash_ctrl #(
    parameter logic [7:0]  CMD_READ  = 8'h03
`ifdef SPI_FLASH_WAKE_EN
    ,
    parameter logic [7:0]  CMD_WAKE  = 8'hAB,
    parameter logic [15:0] WAKE_WAIT = 16'd1000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [23:0] req_len,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic        done,
    output logic        busy,
    output logic        m_enable,
    input  logic        m_idle,
    output logic [7:0]  m_tx_len,
    input  logic        m_tx_fetch,
    output logic [7:0]  m_tx_data,
    output logic [23:0] m_rx_len,
    input  logic        m_rx_store,
    input  logic [7:0]  m_rx_data
);

    typedef enum logic [3:0] {
        S_INIT       = 4'd0,
        S_IDLE       = 4'd1,
        S_START      = 4'd2,
        S_RUN_BUSY   = 4'd3,
        S_RUN        = 4'd4,
        S_DONE       = 4'd5
`ifdef SPI_FLASH_WAKE_EN
        ,
        S_WAKE_ISSUE = 4'd6,
        S_WAKE_BUSY  = 4'd7,
        S_WAKE_WAIT  = 4'd8
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [23:0] len_q, len_d;
    logic [7:0]  tx_len_q, tx_len_d;
    logic [23:0] rx_len_q, rx_len_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] cnt_q, cnt_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_last_q, rd_last_d;
    logic        done_q, done_d;
    logic        m_enable_q, m_enable_d;
    logic        req_fire_s;
`ifdef SPI_FLASH_WAKE_EN
    logic        wake_seen_q, wake_seen_d;
    logic [15:0] wait_q, wait_d;
`endif

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [23:0] addr);
        case (idx)
            3'd0:    hdr_byte = CMD_READ;
            3'd1:    hdr_byte = addr[23:16];
            3'd2:    hdr_byte = addr[15:8];
            3'd3:    hdr_byte = addr[7:0];
            default: hdr_byte = 8'h00;
        endcase
    endfunction

    assign req_ready  = (state_q == S_IDLE) & m_idle;
    assign req_fire_s = req_valid & req_ready;
    assign busy       = (state_q != S_IDLE);
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_last    = rd_last_q;
    assign done       = done_q;
    assign m_enable   = m_enable_q;
    assign m_tx_len   = tx_len_q;
    assign m_rx_len   = rx_len_q;

    // Transmit byte mux: wake opcode during the wake sequence, READ header otherwise
    always_comb begin
`ifdef SPI_FLASH_WAKE_EN
        if (state_q == S_WAKE_ISSUE || state_q == S_WAKE_BUSY || state_q == S_WAKE_WAIT) begin
            m_tx_data = CMD_WAKE;
        end else begin
            m_tx_data = hdr_byte(idx_q, addr_q);
        end
`else
        m_tx_data = hdr_byte(idx_q, addr_q);
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_INIT;
            addr_q     <= 24'd0;
            len_q      <= 24'd0;
            tx_len_q   <= 8'd0;
            rx_len_q   <= 24'd0;
            idx_q      <= 3'd0;
            cnt_q      <= 24'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            m_enable_q <= 1'b0;
`ifdef SPI_FLASH_WAKE_EN
            wake_seen_q <= 1'b0;
            wait_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            tx_len_q   <= tx_len_d;
            rx_len_q   <= rx_len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            m_enable_q <= m_enable_d;
`ifdef SPI_FLASH_WAKE_EN
            wake_seen_q <= wake_seen_d;
            wait_q      <= wait_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef SPI_FLASH_WAKE_EN
            S_INIT:       state_d = S_WAKE_ISSUE;
            S_WAKE_ISSUE: state_d = m_idle ? S_WAKE_BUSY : S_WAKE_ISSUE;
            S_WAKE_BUSY:  begin
                if (wake_seen_q && m_idle) begin
                    state_d = (WAKE_WAIT == 16'd0) ? S_IDLE : S_WAKE_WAIT;
                end else begin
                    state_d = S_WAKE_BUSY;
                end
            end
            S_WAKE_WAIT:  state_d = (wait_q == WAKE_WAIT - 16'd1) ? S_IDLE : S_WAKE_WAIT;
`else
            S_INIT:       state_d = S_IDLE;
`endif
            S_IDLE: begin
                if (req_fire_s) begin
                    state_d = (req_len == 24'd0) ? S_DONE : S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START:      state_d = S_RUN_BUSY;
            S_RUN_BUSY:   state_d = m_idle ? S_RUN_BUSY : S_RUN;
            S_RUN:        state_d = (m_idle && cnt_q == len_q) ? S_DONE : S_RUN;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_INIT;
        endcase
    end

    // Output and datapath next values; pulses are registered off the next state
    always_comb begin
        addr_d     = addr_q;
        len_d      = len_q;
        tx_len_d   = tx_len_q;
        rx_len_d   = rx_len_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_last_d  = 1'b0;
        done_d     = (state_d == S_DONE);
        m_enable_d = (state_d == S_START);
`ifdef SPI_FLASH_WAKE_EN
        wake_seen_d = 1'b0;
        wait_d      = 16'd0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_fire_s) begin
                    addr_d   = req_addr;
                    len_d    = req_len;
                    tx_len_d = 8'd4;
                    rx_len_d = req_len;
                end else begin
                    addr_d = addr_q;
                end
            end
            S_START: begin
                idx_d = 3'd0;
                cnt_d = 24'd0;
            end
            S_RUN_BUSY, S_RUN: begin
                if (m_tx_fetch && idx_q != 3'd4) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    idx_d = idx_q;
                end
                if (m_rx_store) begin
                    cnt_d      = cnt_q + 24'd1;
                    rd_valid_d = 1'b1;
                    rd_data_d  = m_rx_data;
                    rd_last_d  = ((cnt_q + 24'd1) == len_q);
                end else begin
                    cnt_d = cnt_q;
                end
            end
`ifdef SPI_FLASH_WAKE_EN
            S_WAKE_ISSUE: begin
                if (m_idle) begin
                    tx_len_d   = 8'd1;
                    rx_len_d   = 24'd0;
                    m_enable_d = 1'b1;
                end else begin
                    m_enable_d = 1'b0;
                end
            end
            S_WAKE_BUSY:  wake_seen_d = wake_seen_q | ~m_idle;
            S_WAKE_WAIT:  wait_d = wait_q + 16'd1;
`endif
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Self-checking bench for spi_flash_ctrl: behavioural spi_master model plus a byte-level reference.
`timescale 1ns/1ps
module tb_spi_flash_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = 24'd0;
    logic [23:0] req_len = 24'd0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_last;
    logic        done;
    logic        busy;
    logic        m_enable;
    logic        m_idle = 1'b1;
    logic [7:0]  m_tx_len;
    logic        m_tx_fetch = 1'b0;
    logic [7:0]  m_tx_data;
    logic [23:0] m_rx_len;
    logic        m_rx_store = 1'b0;
    logic [7:0]  m_rx_data = 8'd0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

`ifdef SPI_FLASH_WAKE_EN
    spi_flash_ctrl #(.WAKE_WAIT(16'd5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done), .busy(busy),
        .m_enable(m_enable), .m_idle(m_idle), .m_tx_len(m_tx_len), .m_tx_fetch(m_tx_fetch),
        .m_tx_data(m_tx_data), .m_rx_len(m_rx_len), .m_rx_store(m_rx_store), .m_rx_data(m_rx_data)
    );
`else
    spi_flash_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done), .busy(busy),
        .m_enable(m_enable), .m_idle(m_idle), .m_tx_len(m_tx_len), .m_tx_fetch(m_tx_fetch),
        .m_tx_data(m_tx_data), .m_rx_len(m_rx_len), .m_rx_store(m_rx_store), .m_rx_data(m_rx_data)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural spi_master: header bytes first, then rx bytes, with random gaps
    logic [7:0] mosi_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] force_q[$];
    int  en_pulses = 0;
    int  ms_tx_left = 0, ms_rx_left = 0, ms_gap = 0;
    bit  ms_active = 1'b0;

    always @(negedge clk) begin
        m_tx_fetch = 1'b0;
        m_rx_store = 1'b0;
        if (m_enable === 1'b1) en_pulses++;
        if (reset) begin
            ms_active = 1'b0;
            m_idle = 1'b1;
        end else if (!ms_active) begin
            if (m_enable === 1'b1) begin
                ms_active = 1'b1;
                m_idle = 1'b0;
                ms_tx_left = int'(m_tx_len);
                ms_rx_left = int'(m_rx_len);
                ms_gap = 1;
            end
        end else if (ms_gap > 0) begin
            ms_gap--;
        end else if (ms_tx_left > 0) begin
            m_tx_fetch = 1'b1;
            mosi_q.push_back(m_tx_data);
            ms_tx_left--;
            ms_gap = $urandom_range(0, 2);
        end else if (ms_rx_left > 0) begin
            m_rx_store = 1'b1;
            if (force_q.size() > 0) m_rx_data = force_q.pop_front();
            else m_rx_data = 8'($urandom);
            miso_q.push_back(m_rx_data);
            ms_rx_left--;
            ms_gap = $urandom_range(0, 2);
        end else begin
            m_idle = 1'b1;
            ms_active = 1'b0;
        end
    end

    // Output monitor: each accepted store must appear as rd_valid exactly one cycle later
    logic [8:0] rcv_q[$];
    int   done_cnt = 0;
    logic mon_v;
    logic [7:0] mon_d;
    always @(posedge clk) begin
        mon_v = m_rx_store & ~reset;
        mon_d = m_rx_data;
        #1;
        check("rd_valid_latency", rd_valid, mon_v);
        if (mon_v) begin
            check("rd_data", rd_data, mon_d);
            rcv_q.push_back({rd_last, rd_data});
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic clear_obs();
        mosi_q.delete();
        miso_q.delete();
        rcv_q.delete();
        en_pulses = 0;
        done_cnt = 0;
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_req", req_ready, 1'b1);
    endtask

    // Present one request and return half a cycle after the accepting edge
    task automatic start_req(input logic [23:0] a, input logic [23:0] l);
        wait_ready();
        clear_obs();
        req_valid = 1'b1;
        req_addr = a;
        req_len = l;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = 24'($urandom);
        req_len = 24'($urandom);
        if (l != 24'd0) begin
            check("enable_t1", m_enable, 1'b1);
            check("tx_len", m_tx_len, 8'd4);
            check("rx_len", m_rx_len, l);
        end
    endtask

    task automatic check_hdr(input logic [23:0] a);
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h03;
        exp_b[1] = a[23:16];
        exp_b[2] = a[15:8];
        exp_b[3] = a[7:0];
        check("mosi_count", mosi_q.size(), 4);
        for (int i = 0; i < 4 && i < mosi_q.size(); i++) check("mosi_byte", mosi_q[i], exp_b[i]);
    endtask

    task automatic finish_read(input logic [23:0] a, input logic [23:0] l);
        int k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_cnt != 0, 1'b1);
        check("bytes_before_done", rcv_q.size(), l);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("enable_once", en_pulses, (l != 24'd0) ? 1 : 0);
        if (l != 24'd0) check_hdr(a);
        for (int i = 0; i < rcv_q.size() && i < miso_q.size(); i++) begin
            check("stream_data", rcv_q[i][7:0], miso_q[i]);
            check("stream_last", rcv_q[i][8], (i == int'(l) - 1) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp_d [3];
        logic [23:0] ra, rl;
        int k, n;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_enable", m_enable, 1'b0);
        check("reset_rd_last", rd_last, 1'b0);
        check("reset_ready", req_ready, 1'b0);
        check("reset_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b0;
`ifdef SPI_FLASH_WAKE_EN
        k = 0;
        while (m_enable !== 1'b1 && k < 100) begin
            @(negedge clk);
            check("wake_ready_low", req_ready, 1'b0);
            k++;
        end
        check("wake_enable", m_enable, 1'b1);
        check("wake_tx_len", m_tx_len, 8'd1);
        check("wake_rx_len", m_rx_len, 24'd0);
        k = 0;
        while (m_idle !== 1'b0 && k < 100) begin @(posedge clk); k++; end
        while (m_idle !== 1'b1 && k < 200) begin @(posedge clk); k++; end
        check("wake_mosi_count", mosi_q.size(), 1);
        if (mosi_q.size() > 0) check("wake_opcode", mosi_q[0], 8'hAB);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wake_wait_hold", req_ready, 1'b0);
            check("wake_busy", busy, 1'b1);
        end
        @(negedge clk);
        check("wake_ready_after_wait", req_ready, 1'b1);
`else
        @(negedge clk);
        check("init_ready", req_ready, 1'b1);
        check("init_busy", busy, 1'b0);
`endif

        // Known data read
        exp_d[0] = 8'hA5; exp_d[1] = 8'h5A; exp_d[2] = 8'h3C;
        for (int i = 0; i < 3; i++) force_q.push_back(exp_d[i]);
        start_req(24'h123456, 24'd3);
        finish_read(24'h123456, 24'd3);
        for (int i = 0; i < 3 && i < rcv_q.size(); i++) check("known_data", rcv_q[i][7:0], exp_d[i]);

        // Zero-length request
        start_req(24'h000100, 24'd0);
        check("len0_done_t1", done, 1'b1);
        check("len0_ready_t1", req_ready, 1'b0);
        check("len0_no_enable", m_enable, 1'b0);
        @(negedge clk);
        check("len0_ready_t2", req_ready, 1'b1);
        check("len0_done_t2", done, 1'b0);
        finish_read(24'h000100, 24'd0);

        // Request held high while busy: second address taken only after done
        wait_ready();
        clear_obs();
        req_valid = 1'b1; req_addr = 24'hABCDEF; req_len = 24'd2;
        @(negedge clk);
        req_addr = 24'h0F1E2D; req_len = 24'd3;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin @(negedge clk); k++; end
        check("hold_first_done", done_cnt, 1);
        check("hold_single_enable", en_pulses, 1);
        check_hdr(24'hABCDEF);
        check("hold_first_bytes", rcv_q.size(), 2);
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        clear_obs();
        @(negedge clk);
        req_valid = 1'b0;
        check("hold_second_enable", m_enable, 1'b1);
        check("hold_second_rx_len", m_rx_len, 24'd3);
        finish_read(24'h0F1E2D, 24'd3);

        // Top-of-memory single byte
        start_req(24'hFFFFFF, 24'd1);
        finish_read(24'hFFFFFF, 24'd1);

        // Random reads
        for (int t = 0; t < 5; t++) begin
            ra = 24'($urandom);
            rl = 24'($urandom_range(1, 8));
            start_req(ra, rl);
            finish_read(ra, rl);
        end

        // Reset in the middle of a 16-byte read
        start_req(24'h00ABCD, 24'd16);
        k = 0;
        while (rcv_q.size() < 4 && k < 500) begin @(negedge clk); k++; end
        check("midrun_progress", rcv_q.size() >= 4, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        n = rcv_q.size();
        #1;
        check("midrun_rd_valid", rd_valid, 1'b0);
        check("midrun_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_no_more_bytes", rcv_q.size(), n);
        for (int i = 0; i < rcv_q.size(); i++) check("midrun_no_last", rcv_q[i][8], 1'b0);
        start_req(24'h345678, 24'd2);
        finish_read(24'h345678, 24'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_ctrl.md
# spi_flash_ctrl

Read-sequencer placed in front of `spi_master` so SPI NOR flash can be read with a single request handshake. Accepts a 24-bit start address and a byte count, builds the 4-byte READ command header, and drives the `spi_master` user interface. Streams returned bytes out with a last-byte marker. Optionally issues a release-from-power-down command after reset, before accepting any request.

## Interface
- `CMD_READ`, 8'h03, opcode sent as header byte 0.
- `CMD_WAKE`, 8'hAB, release-power-down opcode; used only with `SPI_FLASH_WAKE_EN`.
- `WAKE_WAIT`, 16'd1000, clk cycles to wait after the wake transaction ends; 0 means no wait.

- `clk` in 1: clock.
- `reset` in 1: synchronous reset, active-high. `spi_master.reset_n` is tied to `~reset` at the top level.
- `req_valid` in 1: read request.
- `req_ready` out 1: controller accepts the request this cycle.
- `req_addr` in 24: flash byte address.
- `req_len` in 24: bytes to read; 0 is legal.
- `rd_valid` out 1: one-cycle pulse per received byte.
- `rd_data` out 8: received byte, valid with `rd_valid`.
- `rd_last` out 1: marks the final byte, coincident with `rd_valid`.
- `done` out 1: one-cycle pulse when a request completes.
- `busy` out 1: high whenever state is not IDLE.
- `m_enable` out 1: to `spi_master.enable`.
- `m_idle` in 1: from `spi_master.idle`.
- `m_tx_len` out 8: to `spi_master.tx_len`.
- `m_tx_fetch` in 1: from `spi_master.tx_fetch`.
- `m_tx_data` out 8: to `spi_master.tx_data`.
- `m_rx_len` out 24: to `spi_master.rx_len`.
- `m_rx_store` in 1: from `spi_master.rx_store`.
- `m_rx_data` in 8: from `spi_master.rx_data`.

## Operation
**States:** INIT, WAKE_ISSUE, WAKE_BUSY, WAKE_WAIT, IDLE, START, RUN_BUSY, RUN, DONE.

**Reset** forces INIT. Registered outputs reset to 0: `rd_valid`, `rd_data`, `rd_last`, `done`, `m_enable`.

**INIT**
- Goes to WAKE_ISSUE when the macro is defined.
- Otherwise goes to IDLE.

**Wake sequence**
- WAKE_ISSUE waits for `m_idle`, then asserts `m_enable` for 1 cycle with `m_tx_len`=1, `m_rx_len`=0, `m_tx_data`=`CMD_WAKE`.
- WAKE_BUSY waits for `m_idle`=0, then `m_idle`=1.
- WAKE_WAIT counts `WAKE_WAIT` cycles, then goes to IDLE.

**IDLE**
- `req_ready` = (state==IDLE) & `m_idle`.
- On `req_valid & req_ready`, capture `req_addr` and `req_len` into `addr_q` and `len_q`; later `req_*` changes are ignored.
- If `req_len`==0, go to DONE.
- Otherwise go to START.

**START**
- Asserts `m_enable` for exactly 1 cycle.
- `m_tx_len`=4, `m_rx_len`=`len_q`.
- Clears the byte index and the 24-bit receive counter.
- Next state is RUN_BUSY.

**RUN_BUSY** waits for `m_idle`=0, then goes to RUN.

**RUN**
- `m_tx_data` is combinational on the byte index: 0 gives `CMD_READ`, 1 gives `addr_q[23:16]`, 2 gives `addr_q[15:8]`, 3 gives `addr_q[7:0]`, ≥4 gives 8'h00.
- The index increments on each `m_tx_fetch` and saturates at 4.
- Each `m_rx_store` registers `m_rx_data` into `rd_data` and pulses `rd_valid` next cycle; the receive counter increments.
- `rd_last`=1 when the post-increment count equals `len_q`.
- Leave RUN when `m_idle`=1 and count==`len_q`.

**DONE** pulses `done` for 1 cycle, then goes to IDLE.

**Rules**
- `m_rx_store` outside RUN_BUSY/RUN is ignored and produces no `rd_valid`.
- `m_tx_fetch` in any state other than the wake states, RUN_BUSY and RUN is ignored.
- `m_tx_len` and `m_rx_len` are held stable from START through DONE.
- `req_valid` while busy is not accepted and is not queued.
- `len_q`=24'hFFFFFF is legal: the counter is 24 bits and compares without overflow.

## Timing
- Request accepted in cycle T: `m_enable`=1 in T+1. If `req_len`=0, `done`=1 in T+1 and `req_ready` can return in T+2.
- Read latency: `rd_valid` is exactly 1 cycle after `m_rx_store`.
- `done` follows the cycle in which RUN sees `m_idle`=1 with the full count, and is never before the final `rd_valid`.
- Throughput: one request in flight; no pipelining of requests.
- Reset mid-transaction: the controller returns to INIT the next cycle and drops `rd_valid`/`done`. `spi_master` resets through the shared reset. No partial `rd_last` is emitted afterward.

## Configuration
- `SPI_FLASH_WAKE_EN` defined: the post-reset wake sequence runs; `req_ready` stays 0 and `busy` stays 1 until it finishes.
- Undefined: the wake states are not compiled; INIT goes to IDLE in 1 cycle, and `CMD_WAKE`/`WAKE_WAIT` are unused.

## Test plan
- Macro off, `req_addr`=24'h123456, `req_len`=3; SPI model returns A5,5A,3C → MOSI bytes 03,12,34,56; three `rd_valid` pulses with data A5,5A,3C; `rd_last` only on 3C; one `done` pulse.
- `req_len`=0 → no `m_enable`; `done` in T+1; `req_ready` in T+2.
- Second `req_valid` held during busy with a different address → not accepted until after `done`; second transaction uses its own address.
- Macro on, `WAKE_WAIT`=5 → first MOSI byte AB with `m_rx_len`=0; `req_ready` stays 0 until 5 cycles after `m_idle` returns.
- Reset asserted mid-RUN with `req_len`=16 → `rd_valid`=0 and `done`=0 the next cycle; a fresh request of 2 bytes completes with correct data.
- `req_len`=1, addr 24'hFFFFFF → header 03,FF,FF,FF; single `rd_valid` with `rd_last`=1.
